// File: rtl/m_seq_pkg.sv
// rtl/m_seq_pkg.sv - shared m-sequence definitions for generator and checker
package m_seq_pkg;

    localparam int SEQ_W = 8;
    localparam logic [SEQ_W-1:0] TAP_MASK = 8'h70;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // x^8+x^6+x^5+x^4+1: rotate left, fold the old MSB into bits 4..6
    function automatic logic [SEQ_W-1:0] m_seq_step(input logic [SEQ_W-1:0] s);
        return {s[SEQ_W-2:0], s[SEQ_W-1]} ^ (s[SEQ_W-1] ? TAP_MASK : '0);
    endfunction

endpackage

// File: rtl/m_seq_popcnt8.sv
// rtl/m_seq_popcnt8.sv - 8-bit combinational population count
module m_seq_popcnt8 (
    input  logic [7:0] data,
    output logic [3:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, data[i]};
        end
    end

endmodule

// File: rtl/m_seq_checker.sv
// rtl/m_seq_checker.sv - m-sequence self-synchronising checker with BER counters
module m_seq_checker
    import m_seq_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [SEQ_W-1:0] din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0]       LOSS_LAST = 4'(LOSS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    chk_state_t       state, state_nxt;
    logic [SEQ_W-1:0] expected, exp_nxt;
    logic [3:0]       match_cnt, match_nxt;
    logic [3:0]       miss_cnt, miss_nxt;
    logic             chk_word, chk_err;
    logic [3:0]       pop;
    logic [CNT_W:0]   bit_sum;

    m_seq_popcnt8 u_popcnt (
        .data (din ^ expected),
        .cnt  (pop)
    );

    // one spare bit so the accumulate can be clamped instead of wrapping
    assign bit_sum = {1'b0, bit_err_cnt} + {{(CNT_W-3){1'b0}}, pop};
    assign locked  = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        exp_nxt   = expected;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        chk_word  = 1'b0;
        chk_err   = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (din != '0) begin
                        exp_nxt   = m_seq_step(din);
                        match_nxt = '0;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (din == '0) begin
                        state_nxt = HUNT;
                    end else if (din == expected) begin
                        exp_nxt = m_seq_step(din);
                        if (match_cnt == LOCK_LAST) begin
                            match_nxt = '0;
                            miss_nxt  = '0;
                            state_nxt = LOCKED;
                        end else begin
                            match_nxt = match_cnt + 4'd1;
                        end
                    end else begin
                        exp_nxt   = m_seq_step(din);
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    // flywheel: received data never reseeds the predictor here
                    exp_nxt  = m_seq_step(expected);
                    chk_word = 1'b1;
                    if (din == expected) begin
                        miss_nxt = '0;
                    end else begin
                        chk_err = 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            miss_nxt  = '0;
                            state_nxt = HUNT;
                        end else begin
                            miss_nxt = miss_cnt + 4'd1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            expected    <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            bit_err_cnt <= '0;
            word_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            expected  <= exp_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_pulse <= chk_err;
            if (clr_cnt) begin
                err_cnt     <= '0;
                bit_err_cnt <= '0;
                word_cnt    <= '0;
            end else begin
                if (chk_word && word_cnt != CNT_MAX) begin
                    word_cnt <= word_cnt + CNT_ONE;
                end
                if (chk_err && err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
                if (chk_err) begin
                    bit_err_cnt <= bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_m_seq_checker.sv
// tb/tb_m_seq_checker.sv - directed self-checking bench for m_seq_checker
module tb_m_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic [7:0]  din;
    logic        clr_cnt;

    logic        locked, err_pulse;
    logic [15:0] err_cnt, bit_err_cnt, word_cnt;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_cnt, s_bit_err_cnt, s_word_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    m_seq_checker dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .clr_cnt     (clr_cnt),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt),
        .bit_err_cnt (bit_err_cnt),
        .word_cnt    (word_cnt)
    );

    m_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .clr_cnt     (clr_cnt),
        .locked      (s_locked),
        .err_pulse   (s_err_pulse),
        .err_cnt     (s_err_cnt),
        .bit_err_cnt (s_bit_err_cnt),
        .word_cnt    (s_word_cnt)
    );

    function automatic logic [7:0] tb_step(input logic [7:0] s);
        logic [7:0] n;
        n[0] = s[7];
        n[1] = s[0];
        n[2] = s[1];
        n[3] = s[2];
        n[4] = s[3] ^ s[7];
        n[5] = s[4] ^ s[7];
        n[6] = s[5] ^ s[7];
        n[7] = s[6];
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] d);
        din_valid = 1'b1;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 8'h00;
        clr_cnt   = 1'b0;
        idle(2);
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_bit_err_cnt", bit_err_cnt, 0);
        chk("rst_word_cnt", word_cnt, 0);
        rst = 1'b0;

        // lock from 01 with four matches
        send(8'h01); send(8'h02); send(8'h04); send(8'h08);
        chk("lock_not_yet", locked, 0);
        send(8'h10);
        chk("lock_up", locked, 1);
        chk("lock_word_cnt0", word_cnt, 0);
        chk("lock_err_cnt0", err_cnt, 0);
        send(8'h20); send(8'h40); send(8'h80); send(8'h71);
        chk("lock_word_cnt4", word_cnt, 4);
        chk("lock_err_cnt_clean", err_cnt, 0);
        chk("lock_bit_clean", bit_err_cnt, 0);

        // single bit error, flywheel continues
        pulse_rst();
        send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h10);
        send(8'h21);
        chk("single_err_pulse", err_pulse, 1);
        chk("single_err_cnt", err_cnt, 1);
        chk("single_bit_cnt", bit_err_cnt, 1);
        send(8'h40);
        chk("single_pulse_drop", err_pulse, 0);
        chk("single_err_hold", err_cnt, 1);
        send(8'h80);
        chk("single_word_cnt", word_cnt, 3);
        chk("single_locked", locked, 1);

        // loss of lock: expected 71,E2,B5,1B, popcounts 4+4+5+4
        send(8'h00); send(8'h00); send(8'h00);
        chk("loss_still_locked", locked, 1);
        send(8'h00);
        chk("loss_unlocked", locked, 0);
        chk("loss_err_cnt", err_cnt, 5);
        chk("loss_bit_cnt", bit_err_cnt, 18);
        chk("loss_word_cnt", word_cnt, 7);

        // HUNT ignores zeros; reseed on 55 in SYNC
        send(8'h00); send(8'h00);
        chk("hunt_zero_stay", locked, 0);
        chk("hunt_no_count", err_cnt, 5);
        send(8'h01); send(8'h02); send(8'h55);
        send(8'hAA); send(8'h25); send(8'h4A);
        chk("reseed_not_locked", locked, 0);
        send(8'h94);
        chk("reseed_locked", locked, 1);
        chk("sync_no_word_count", word_cnt, 7);

        // bubbles between locked words
        send(8'h59);
        idle(2);
        chk("gap_no_pulse", err_pulse, 0);
        chk("gap_word_cnt8", word_cnt, 8);
        send(8'hB2);
        idle(1);
        chk("gap_word_cnt9", word_cnt, 9);
        chk("gap_err_cnt", err_cnt, 5);

        // clear coincident with an error (expected 15)
        clr_cnt = 1'b1;
        send(8'h14);
        clr_cnt = 1'b0;
        chk("clr_err_pulse", err_pulse, 1);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_bit_cnt", bit_err_cnt, 0);
        chk("clr_word_cnt", word_cnt, 0);
        chk("clr_keeps_lock", locked, 1);
        send(8'h2A);
        chk("post_clr_word", word_cnt, 1);
        chk("post_clr_pulse", err_pulse, 0);

        // reset mid-lock
        pulse_rst();
        chk("midrst_locked", locked, 0);
        chk("midrst_word", word_cnt, 0);
        chk("midrst_pulse", err_pulse, 0);

        // saturation on the 4-bit instance
        send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h10);
        chk("sat_locked", s_locked, 1);
        exp_w = 8'h20;
        for (int i = 0; i < 20; i++) begin
            send(~exp_w);
            exp_w = tb_step(exp_w);
            if (i == 0) begin
                chk("sat_bit_first", s_bit_err_cnt, 8);
                chk("sat_err_first", s_err_cnt, 1);
            end
            if (i == 1) begin
                chk("sat_bit_clamp", s_bit_err_cnt, 15);
            end
            send(exp_w);
            exp_w = tb_step(exp_w);
        end
        chk("sat_err_cnt", s_err_cnt, 15);
        chk("sat_bit_cnt", s_bit_err_cnt, 15);
        chk("sat_word_cnt", s_word_cnt, 15);
        chk("sat_still_locked", s_locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
